// File: rtl/insn_arb_pkg.sv
// Shared types and default widths for the instruction-memory arbiter.
// The optional fetch-stall counter is enabled with macro INSN_ARB_STATS_EN.
package insn_arb_pkg;

    localparam int unsigned ADDR_W_DEF  = 4;
    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned STALL_CNT_W = 16;

    // Arbiter operating mode: normal arbitration or exclusive loader burst.
    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    // Identity of the requester that was granted most recently.
    typedef enum logic {
        REQ_FETCH = 1'b0,
        REQ_LOAD  = 1'b1
    } req_id_e;

endpackage

// File: rtl/insn_arb_rr.sv
// Two-requester round-robin pick (fetch vs. loader) with the last_grant register.
// l_prio_i lets the loader win a tie regardless of history (lock requests).
module insn_arb_rr
    import insn_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic f_req_i,
    input  logic l_req_i,
    input  logic l_prio_i,
    output logic f_gnt_o,
    output logic l_gnt_o
);

    req_id_e last_q, last_d;

    // Pick: loader wins when alone, when prioritised, or when fetch went last.
    always_comb begin
        l_gnt_o = l_req_i & (~f_req_i | l_prio_i | (last_q == REQ_FETCH));
        f_gnt_o = f_req_i & ~l_gnt_o;
    end

    // Remember whoever was granted; history is untouched in idle cycles.
    always_comb begin
        last_d = last_q;
        if (l_gnt_o) begin
            last_d = REQ_LOAD;
        end else if (f_gnt_o) begin
            last_d = REQ_FETCH;
        end
    end

    // last_grant register; reset favours the loader on the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_FETCH;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/insn_mem_arbiter.sv
// Arbiter sharing a single-port instruction memory between the core fetch
// port and a loader port, with an exclusive loader burst mode (LOCK).
// Define INSN_ARB_STATS_EN to add the saturating f_stall_cnt output.
module insn_mem_arbiter
    import insn_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              l_req,
    input  logic              l_we,
    input  logic              l_lock,
    input  logic [ADDR_W-1:0] l_addr,
    input  logic [DATA_W-1:0] l_wdata,
    output logic              l_gnt,
    output logic              l_rvalid,
    output logic [DATA_W-1:0] l_rdata,
    output logic              core_stall,
`ifdef INSN_ARB_STATS_EN
    output logic [STALL_CNT_W-1:0] f_stall_cnt,
`endif
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e state_q, state_d;
    logic       lock_hold;
    logic       rr_f_req, rr_l_req;
    logic       rr_f_gnt, rr_l_gnt;
    logic       f_rvalid_q, l_rvalid_q;

    // In LOCK with l_lock still high, fetch is masked so the loader always
    // wins; grants are forced low while reset is asserted.
    always_comb begin
        lock_hold = (state_q == LOCK) & l_lock;
        rr_f_req  = f_req & rst_n & ~lock_hold;
        rr_l_req  = l_req & rst_n;
    end

    insn_arb_rr u_rr (
        .clk      (clk),
        .rst_n    (rst_n),
        .f_req_i  (rr_f_req),
        .l_req_i  (rr_l_req),
        .l_prio_i (l_lock),
        .f_gnt_o  (rr_f_gnt),
        .l_gnt_o  (rr_l_gnt)
    );

    // Next-state and grant/stall outputs; core_stall also covers the cycle
    // in which the lock is granted, so the stall spans every locked access.
    always_comb begin
        state_d    = state_q;
        f_gnt      = rr_f_gnt;
        l_gnt      = rr_l_gnt;
        core_stall = lock_hold | (rr_l_gnt & l_lock);
        unique case (state_q)
            ARB: begin
                if (rr_l_gnt & l_lock) begin
                    state_d = LOCK;
                end
            end
            LOCK: begin
                if (!l_lock) begin
                    state_d = ARB;
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Memory command: the loader owns address/data whenever granted.
    always_comb begin
        mem_en    = f_gnt | l_gnt;
        mem_we    = l_gnt & l_we;
        mem_addr  = l_gnt ? l_addr : f_addr;
        mem_wdata = l_wdata;
        f_rdata   = mem_rdata;
        l_rdata   = mem_rdata;
        f_rvalid  = f_rvalid_q;
        l_rvalid  = l_rvalid_q;
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // Read-valid pipeline matching the memory's one-cycle read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            f_rvalid_q <= 1'b0;
            l_rvalid_q <= 1'b0;
        end else begin
            f_rvalid_q <= f_gnt;
            l_rvalid_q <= l_gnt & ~l_we;
        end
    end

`ifdef INSN_ARB_STATS_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    // Count cycles where fetch waits, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (f_req & ~f_gnt & (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        f_stall_cnt = stall_cnt_q;
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_insn_mem_arbiter.sv
// Self-checking bench for insn_mem_arbiter: a directed vector table, hand
// sequences for multi-cycle cases, and randomized traffic against a
// behavioural model. Stats checks are compiled with INSN_ARB_STATS_EN.
module tb_insn_mem_arbiter;

    localparam int AW = 4;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          f_req = 1'b0, l_req = 1'b0, l_we = 1'b0, l_lock = 1'b0;
    logic [AW-1:0] f_addr = '0, l_addr = '0;
    logic [DW-1:0] l_wdata = '0;
    logic          f_gnt, l_gnt, f_rvalid, l_rvalid, core_stall, mem_en, mem_we;
    logic [DW-1:0] f_rdata, l_rdata, mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic [AW-1:0] mem_addr;
`ifdef INSN_ARB_STATS_EN
    logic [15:0]   f_stall_cnt;
`endif

    always #5 clk = ~clk;

    insn_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .f_req      (f_req),
        .f_addr     (f_addr),
        .f_gnt      (f_gnt),
        .f_rvalid   (f_rvalid),
        .f_rdata    (f_rdata),
        .l_req      (l_req),
        .l_we       (l_we),
        .l_lock     (l_lock),
        .l_addr     (l_addr),
        .l_wdata    (l_wdata),
        .l_gnt      (l_gnt),
        .l_rvalid   (l_rvalid),
        .l_rdata    (l_rdata),
        .core_stall (core_stall),
`ifdef INSN_ARB_STATS_EN
        .f_stall_cnt(f_stall_cnt),
`endif
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    // Environment: single-port memory with one-cycle read latency.
    logic [DW-1:0] mem [16];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr];
        end
    end

    // Behavioural model state.
    bit            m_locked;     // loader owns the memory exclusively
    bit            m_last_load;  // most recent grant went to the loader
    logic [DW-1:0] m_mem [16];
    bit            m_frv, m_lrv;
    logic [DW-1:0] m_fdata, m_ldata;
    int            m_stall_cnt;

    int checks = 0;
    int failures = 0;

    // Values seen at the latest sample point.
    bit            s_fg, s_lg, s_stall, s_frv;
    logic [DW-1:0] s_fdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, predict, sample at negedge, advance the model.
    task automatic cycle(input bit rst, input bit fr, input bit lr, input bit we, input bit lk,
                         input logic [AW-1:0] fa, input logic [AW-1:0] la,
                         input logic [DW-1:0] wd);
        bit ef, el, es;
        rst_n = rst; f_req = fr; l_req = lr; l_we = we; l_lock = lk;
        f_addr = fa; l_addr = la; l_wdata = wd;
        if (!rst) begin
            ef = 0; el = 0; es = 0;
            m_frv = 0; m_lrv = 0; m_locked = 0; m_last_load = 0; m_stall_cnt = 0;
        end else if (m_locked && lk) begin
            ef = 0; el = lr; es = 1;
        end else begin
            // A lock request beats fetch; otherwise ties go to whoever waited.
            el = lr && (!fr || lk || !m_last_load);
            ef = fr && !el;
            es = lr && lk;
        end
        @(negedge clk);
        check("f_gnt", f_gnt, ef);
        check("l_gnt", l_gnt, el);
        check("core_stall", core_stall, es);
        check("mem_en", mem_en, ef | el);
        check("mem_we", mem_we, el & we);
        if (ef | el) check("mem_addr", mem_addr, el ? la : fa);
        if (el && we) check("mem_wdata", mem_wdata, wd);
        check("f_rvalid", f_rvalid, m_frv);
        if (m_frv) check("f_rdata", f_rdata, m_fdata);
        check("l_rvalid", l_rvalid, m_lrv);
        if (m_lrv) check("l_rdata", l_rdata, m_ldata);
`ifdef INSN_ARB_STATS_EN
        check("f_stall_cnt", f_stall_cnt, m_stall_cnt);
`endif
        s_fg = f_gnt; s_lg = l_gnt; s_stall = core_stall; s_frv = f_rvalid; s_fdata = f_rdata;
        @(posedge clk);
        #1;
        if (rst) begin
            m_frv = ef;
            if (ef) m_fdata = m_mem[fa];
            m_lrv = el && !we;
            if (m_lrv) m_ldata = m_mem[la];
            if (el && we) m_mem[la] = wd;
            m_locked = lk && (m_locked || el);
            if (el) m_last_load = 1;
            else if (ef) m_last_load = 0;
            if (fr && !ef && m_stall_cnt < 16'hFFFF) m_stall_cnt++;
        end
    endtask

    task automatic idle();
        cycle(1, 0, 0, 0, 0, '0, '0, '0);
    endtask

    task automatic do_reset();
        cycle(0, 1, 1, 0, 1, '0, '0, '0);
        cycle(0, 1, 1, 1, 0, 4'd2, 4'd2, 16'hFFFF);
    endtask

    typedef struct {
        bit            fr, lr, we, lk;
        logic [AW-1:0] fa, la;
        logic [DW-1:0] wd;
        bit            efg, elg, est, efrv;
        logic [DW-1:0] efd;
    } vec_t;

    vec_t tbl [15];

    initial begin
        int nl, nf, lock_run, stall_hi;
        for (int i = 0; i < 16; i++) begin
            mem[i]   = DW'(i * 16'h1111);
            m_mem[i] = DW'(i * 16'h1111);
        end
        m_locked = 0; m_last_load = 0; m_frv = 0; m_lrv = 0; m_stall_cnt = 0;

        //            fr lr we lk  fa     la     wd         fg lg st frv fdata
        tbl[0]  = '{1, 1, 1, 0, 4'd3, 4'd3, 16'h00AB, 0, 1, 0, 0, 16'h0000};
        tbl[1]  = '{1, 0, 0, 0, 4'd3, 4'd0, 16'h0000, 1, 0, 0, 0, 16'h0000};
        tbl[2]  = '{0, 0, 0, 0, 4'd0, 4'd0, 16'h0000, 0, 0, 0, 1, 16'h00AB};
        tbl[3]  = '{0, 1, 0, 0, 4'd0, 4'd3, 16'h0000, 0, 1, 0, 0, 16'h0000};
        tbl[4]  = '{0, 0, 0, 0, 4'd0, 4'd0, 16'h0000, 0, 0, 0, 0, 16'h0000};
        tbl[5]  = '{1, 0, 0, 1, 4'd7, 4'd0, 16'h0000, 1, 0, 0, 0, 16'h0000};
        tbl[6]  = '{1, 0, 0, 0, 4'd7, 4'd0, 16'h0000, 1, 0, 0, 1, 16'h7777};
        tbl[7]  = '{1, 1, 0, 0, 4'd1, 4'd2, 16'h0000, 0, 1, 0, 1, 16'h7777};
        tbl[8]  = '{1, 1, 0, 0, 4'd1, 4'd2, 16'h0000, 1, 0, 0, 0, 16'h0000};
        tbl[9]  = '{0, 1, 0, 0, 4'd0, 4'd4, 16'h0000, 0, 1, 0, 1, 16'h1111};
        tbl[10] = '{1, 1, 1, 1, 4'd5, 4'd5, 16'h1234, 0, 1, 1, 0, 16'h0000};
        tbl[11] = '{1, 0, 0, 1, 4'd5, 4'd0, 16'h0000, 0, 0, 1, 0, 16'h0000};
        tbl[12] = '{1, 1, 0, 1, 4'd5, 4'd5, 16'h0000, 0, 1, 1, 0, 16'h0000};
        tbl[13] = '{1, 1, 0, 0, 4'd5, 4'd6, 16'h0000, 1, 0, 0, 0, 16'h0000};
        tbl[14] = '{0, 0, 0, 0, 4'd0, 4'd0, 16'h0000, 0, 0, 0, 1, 16'h1234};

        // Reset: requests present but nothing granted.
        do_reset();

        for (int i = 0; i < 15; i++) begin
            cycle(1, tbl[i].fr, tbl[i].lr, tbl[i].we, tbl[i].lk,
                  tbl[i].fa, tbl[i].la, tbl[i].wd);
            check($sformatf("vec%0d_f_gnt", i), s_fg, tbl[i].efg);
            check($sformatf("vec%0d_l_gnt", i), s_lg, tbl[i].elg);
            check($sformatf("vec%0d_stall", i), s_stall, tbl[i].est);
            check($sformatf("vec%0d_f_rvalid", i), s_frv, tbl[i].efrv);
            if (tbl[i].efrv) check($sformatf("vec%0d_f_rdata", i), s_fdata, tbl[i].efd);
        end

        // Continuous contention from reset: L,F,L,F... four each.
        do_reset();
        nl = 0; nf = 0;
        for (int i = 0; i < 8; i++) begin
            cycle(1, 1, 1, 0, 0, 4'(i), 4'(i + 8), '0);
            check("rr_alternate", s_lg, (i % 2) == 0);
            nl += int'(s_lg); nf += int'(s_fg);
        end
        check("rr_load_count", nl, 4);
        check("rr_fetch_count", nf, 4);

        // Locked burst of 11 writes while fetch keeps requesting.
        do_reset();
        stall_hi = 0; nf = 0;
        for (int i = 0; i < 11; i++) begin
            cycle(1, 1, 1, 1, 1, 4'd10, 4'(i), 16'hC000 + 16'(i));
            stall_hi += int'(s_stall); nf += int'(s_fg);
        end
        check("burst_stall_cycles", stall_hi, 11);
        check("burst_fetch_grants", nf, 0);
        cycle(1, 1, 0, 0, 0, 4'd10, '0, '0);
        check("burst_exit_f_gnt", s_fg, 1);
        check("burst_exit_stall", s_stall, 0);
        idle();
        check("burst_readback", s_fdata, 16'hC00A);

        // Reset in the cycle after a fetch grant drops the pending rvalid.
        cycle(1, 1, 0, 0, 0, 4'd4, '0, '0);
        check("pre_reset_f_gnt", s_fg, 1);
        cycle(0, 0, 0, 0, 0, '0, '0, '0);
        check("in_reset_f_rvalid", s_frv, 0);
        idle();
        check("post_reset_f_rvalid", s_frv, 0);
        check("post_reset_stall", s_stall, 0);
        cycle(1, 1, 1, 0, 0, 4'd1, 4'd2, '0);
        check("post_reset_tie_to_load", s_lg, 1);

`ifdef INSN_ARB_STATS_EN
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 1, 1, 1, 1, 4'd0, 4'(i), 16'h5A5A);
        cycle(1, 0, 0, 0, 0, '0, '0, '0);
        check("stall_cnt_lock5", f_stall_cnt, 16'd5);
        for (int i = 0; i < 65535; i++) cycle(1, 1, 1, 0, 1, 4'd0, 4'd1, '0);
        idle();
        check("stall_cnt_saturated", f_stall_cnt, 16'hFFFF);
`endif

        // Randomized traffic, with occasional lock bursts and resets.
        lock_run = 0;
        for (int i = 0; i < 400; i++) begin
            bit lk;
            if (lock_run > 0) begin
                lk = 1; lock_run--;
            end else if ($urandom_range(9) == 0) begin
                lk = 1; lock_run = int'($urandom_range(6));
            end else begin
                lk = 0;
            end
            cycle($urandom_range(49) != 0, 1'($urandom), 1'($urandom), 1'($urandom), lk,
                  4'($urandom), 4'($urandom), 16'($urandom));
        end
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
